// File: rtl/disp_pkg.sv
// Shared display-path definitions: converter state encoding, digit codes,
// and a constant power-of-ten helper used to size the overflow bound.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] DIGIT_DASH = 4'd10;

  // 10**n as a 64-bit constant; only ever evaluated at elaboration time.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bin_to_digits_if.sv
// Request/result bundle between a value source and the digit converter.
interface bin_to_digits_if
  import disp_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);

  logic                      start;
  logic [BIN_W-1:0]          value;
  logic                      busy;
  logic                      done;
  logic                      ovf;
  logic [DIGIT_W*DIGITS-1:0] digits;

  modport master (
    output start, value,
    input  busy, done, ovf, digits
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, digits
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD lane correction for shift-and-add-3: a nibble of 5 or more is
// bumped by 3 so that the following left shift carries into the next digit.
module bcd_digit_adj
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // add-3 correction for nibbles that would exceed 9 after doubling
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_digits_chk.sv
// Protocol checks on the converter outputs: results only move with done,
// done only occurs while busy, and an overflow result is always all dashes.
module bin_to_digits_chk
  import disp_pkg::*;
#(
  parameter int DIGITS = 6
)(
  input logic                      clk,
  input logic                      rst,
  input logic                      busy,
  input logic                      done,
  input logic                      ovf,
  input logic [DIGIT_W*DIGITS-1:0] digits
);

  localparam logic [DIGIT_W*DIGITS-1:0] ALL_DASH = {DIGITS{DIGIT_DASH}};

  a_done_busy: assert property (@(posedge clk) disable iff (rst) done |-> busy)
    else $error("done asserted while not busy");

  a_digits_hold: assert property (@(posedge clk) disable iff (rst) !$stable(digits) |-> done)
    else $error("digits changed without done");

  a_ovf_dash: assert property (@(posedge clk) disable iff (rst) ovf |-> (digits == ALL_DASH))
    else $error("ovf set without dash digits");

endmodule

// File: rtl/bin_to_digits.sv
// Sequential binary-to-decimal converter for the HEX display bank.
// Shift-and-add-3, one input bit per cycle; the result is published on a
// single DONE edge so the displays never show a partially built number.
module bin_to_digits
  import disp_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
)(
  input  logic            clk,
  input  logic            rst,
  bin_to_digits_if.slave  bus
);

  localparam int          BCD_W     = DIGIT_W * DIGITS;
  localparam int          CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0] OVF_BOUND = pow10(DIGITS);

  conv_state_t      state_r, state_s;
  logic [BIN_W-1:0] shift_r, shift_s;
  logic [BCD_W-1:0] bcd_r, bcd_s;
  logic [BCD_W-1:0] adj_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             ovf_flag_r, ovf_flag_s;
  logic             ovf_cap_s;

  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             ovf_r, ovf_s;
  logic [BCD_W-1:0] digits_r, digits_s;

  // Per-lane add-3 correction applied to the current accumulator.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (bcd_r[g*DIGIT_W +: DIGIT_W]),
        .dout (adj_s[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Out-of-range test against a constant bound; evaluated only at capture.
  assign ovf_cap_s = (64'(bus.value) >= OVF_BOUND);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, datapath next values and registered-output next values
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bcd_s      = bcd_r;
    cnt_s      = cnt_r;
    ovf_flag_s = ovf_flag_r;
    digits_s   = digits_r;
    ovf_s      = ovf_r;
    done_s     = 1'b0;
    busy_s     = 1'b1;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s    = SHIFT;
          shift_s    = bus.value;
          bcd_s      = {BCD_W{1'b0}};
          cnt_s      = CNT_W'(BIN_W);
          ovf_flag_s = ovf_cap_s;
          busy_s     = 1'b1;
        end else begin
          busy_s     = 1'b0;
        end
      end

      SHIFT: begin
        // Corrected accumulator and operand shift left together as one word;
        // the accumulator MSB falls off only for out-of-range inputs.
        bcd_s   = {adj_s[BCD_W-2:0], shift_r[BIN_W-1]};
        shift_s = shift_r << 1'b1;
        cnt_s   = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end

      DONE: begin
        state_s = IDLE;
        done_s  = 1'b1;
        ovf_s   = ovf_flag_r;
        if (ovf_flag_r) begin
          digits_s = {DIGITS{DIGIT_DASH}};
        end else begin
          digits_s = bcd_r;
        end
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Conversion working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= {BIN_W{1'b0}};
      bcd_r      <= {BCD_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ovf_flag_r <= 1'b0;
    end else begin
      shift_r    <= shift_s;
      bcd_r      <= bcd_s;
      cnt_r      <= cnt_s;
      ovf_flag_r <= ovf_flag_s;
    end
  end

  // Registered outputs; digits/ovf move only on the DONE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      digits_r <= {BCD_W{1'b0}};
    end else begin
      busy_r   <= busy_s;
      done_r   <= done_s;
      ovf_r    <= ovf_s;
      digits_r <= digits_s;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.ovf    = ovf_r;
  assign bus.digits = digits_r;

  bin_to_digits_chk #(
    .DIGITS (DIGITS)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy_r),
    .done   (done_r),
    .ovf    (ovf_r),
    .digits (digits_r)
  );

endmodule
